// File: rtl/mux_cfg_chain_loader.sv
// rtl/mux_cfg_chain_loader.sv - serializes bitstream words into a mux config chain, then rotates it once for a parity readback
module mux_cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 60,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bits_req_q, bits_req_d;
    logic [CNT_W-1:0]  bits_shifted_q, bits_shifted_d;
    logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]  chk_cnt_q, chk_cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              parity_load_q, parity_load_d;
    logic              parity_rd_q, parity_rd_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  take_cnt;
    logic              start_load;

    assign error = error_q;

    // Bits taken from the next word: the final word may carry more bits than the chain still needs.
    always_comb begin
        take_cnt = bits_req_q;
        if (32'(bits_req_q) >= WORD_W) begin
            take_cnt = WORD_W_C;
        end
    end

    assign start_load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d        = state_q;
        bits_req_d     = bits_req_q;
        bits_shifted_d = bits_shifted_q;
        buf_cnt_d      = buf_cnt_q;
        chk_cnt_d      = chk_cnt_q;
        buf_d          = buf_q;
        parity_load_d  = parity_load_q;
        parity_rd_d    = parity_rd_q;
        error_d        = error_q;
        word_ready     = 1'b0;
        ccff_head      = 1'b0;
        ccff_shift_en  = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_LOAD: begin
                busy       = 1'b1;
                word_ready = (bits_req_q != '0) && (buf_cnt_q <= CNT_W'(1));
                if (buf_cnt_q != '0) begin
                    ccff_shift_en  = 1'b1;
                    ccff_head      = buf_q[0];
                    buf_d          = buf_q >> 1;
                    buf_cnt_d      = buf_cnt_q - CNT_W'(1);
                    parity_load_d  = parity_load_q ^ buf_q[0];
                    bits_shifted_d = bits_shifted_q + CNT_W'(1);
                    if (bits_shifted_q == LAST_C) begin
                        state_d     = S_CHECK;
                        chk_cnt_d   = '0;
                        parity_rd_d = 1'b0;
                    end
                end
                // A refill while the last buffered bit drains keeps the stream gap-free.
                if (word_ready && word_valid) begin
                    buf_d      = word_data;
                    buf_cnt_d  = take_cnt;
                    bits_req_d = bits_req_q - take_cnt;
                end
            end
            S_CHECK: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                parity_rd_d   = parity_rd_q ^ ccff_tail;
                chk_cnt_d     = chk_cnt_q + CNT_W'(1);
                if (chk_cnt_q == LAST_C) begin
                    error_d = ((parity_rd_q ^ ccff_tail) != parity_load_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_load) begin
            state_d        = S_LOAD;
            bits_req_d     = CHAIN_LEN_C;
            bits_shifted_d = '0;
            buf_cnt_d      = '0;
            parity_load_d  = 1'b0;
            error_d        = 1'b0;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q        <= S_IDLE;
            bits_req_q     <= '0;
            bits_shifted_q <= '0;
            buf_cnt_q      <= '0;
            chk_cnt_q      <= '0;
            buf_q          <= '0;
            parity_load_q  <= 1'b0;
            parity_rd_q    <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            bits_req_q     <= bits_req_d;
            bits_shifted_q <= bits_shifted_d;
            buf_cnt_q      <= buf_cnt_d;
            chk_cnt_q      <= chk_cnt_d;
            buf_q          <= buf_d;
            parity_load_q  <= parity_load_d;
            parity_rd_q    <= parity_rd_d;
            error_q        <= error_d;
        end
    end

endmodule

// File: tb/tb_mux_cfg_chain_loader.sv
// tb/tb_mux_cfg_chain_loader.sv - vector table, random gaps and corner sequences against chain and timeline models
module tb_mux_cfg_chain_loader;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
    logic        flip;
    logic [59:0] chain;

    logic        s_start, s_valid, s_ready, s_head, s_sen, s_tail, s_busy, s_done, s_err;
    logic [7:0]  s_data;
    logic [5:0]  chain6;

    int total = 0;
    int bad   = 0;

    always #5 prog_clk = ~prog_clk;

    mux_cfg_chain_loader u_dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error)
    );

    mux_cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(6), .CNT_W(4)) u_small (
        .prog_clk(prog_clk), .pReset(pReset), .start(s_start),
        .word_data(s_data), .word_valid(s_valid), .word_ready(s_ready),
        .ccff_head(s_head), .ccff_shift_en(s_sen), .ccff_tail(s_tail),
        .busy(s_busy), .done(s_done), .error(s_err)
    );

    // Chain models: index 0 is the head flip-flop, the top index drives the tail.
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[58:0], ccff_head};
    assign ccff_tail = chain[59] ^ flip;
    always @(posedge prog_clk) if (s_sen) chain6 <= {chain6[4:0], s_head};
    assign s_tail = chain6[5];

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          g0;
        int          g1;
        bit          inj;
        bit          sic;
        int          exp_done;
        bit          exp_err;
        bit          chk_chain;
    } vec_t;

    vec_t vecs[5];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [59:0] exp_chain(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] s;
        logic [59:0] c;
        s = {w1, w0};
        for (int j = 0; j < 60; j++) c[59-j] = s[j];
        return c;
    endfunction

    // g0: cycles word 0 is withheld; g1: cycles word 1 is withheld once the buffer is down to its last bit.
    task automatic run_load(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input int g0, input int g1, input bit inj, input bit sic,
                            input int exp_done, input bit exp_err, input bit chk_chain);
        int a0, avail1, nacc, shifts, gap_bad, done_cyc;
        @(negedge prog_clk);
        start = 1'b1;
        word_valid = 1'b0;
        flip = 1'b0;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        nacc = 0; shifts = 0; gap_bad = 0; done_cyc = -1; a0 = 0; avail1 = 1 << 30;
        for (int k = 1; k <= 400; k++) begin
            if (nacc == 0 && k >= 1 + g0) begin
                word_valid = 1'b1; word_data = w0;
            end else if (nacc == 1 && k >= avail1) begin
                word_valid = 1'b1; word_data = w1;
            end else begin
                word_valid = 1'b0; word_data = $urandom;
            end
            start = sic && (k == exp_done - 40);
            flip  = inj && (k == exp_done - 30);
            @(negedge prog_clk);
            if (k == 1) begin
                check_eq({tag, "_err_clear"}, error, 0);
                check_eq({tag, "_entry"}, {busy, done}, 2'b10);
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            if (ccff_shift_en) shifts++;
            if (nacc == 1 && k >= a0 + 32 && k < avail1 && !word_ready) gap_bad++;
            if (word_valid && word_ready) begin
                if (nacc == 0) begin
                    a0 = k;
                    avail1 = k + 32 + g1;
                end
                nacc++;
            end
            @(posedge prog_clk);
            #1;
        end
        start = 1'b0; flip = 1'b0; word_valid = 1'b0;
        check_eq({tag, "_done_cycle"}, done_cyc, exp_done);
        check_eq({tag, "_error"}, error, exp_err);
        check_eq({tag, "_shift_cycles"}, shifts, 120);
        check_eq({tag, "_transfers"}, nacc, 2);
        check_eq({tag, "_ready_in_gap"}, gap_bad, 0);
        if (chk_chain) check_eq({tag, "_chain"}, chain, exp_chain(w0, w1));
    endtask

    initial begin
        int sh, done_cyc, xfers;
        logic [31:0] rw0, rw1;
        int rg0, rg1;
        logic [5:0] e6;
        logic [7:0] sw;

        vecs[0] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0, 1'b0, 1'b0, 122, 1'b0, 1'b1};
        vecs[1] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 0, 5, 1'b0, 1'b0, 127, 1'b0, 1'b1};
        vecs[2] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0, 1'b1, 1'b0, 122, 1'b1, 1'b0};
        vecs[3] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0, 1'b0, 1'b0, 122, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'hDEADBEEF, 2, 3, 1'b0, 1'b1, 127, 1'b0, 1'b1};

        pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0; flip = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        check_eq("reset_outputs", {word_ready, ccff_shift_en, ccff_head, busy, done, error}, 0);
        @(negedge prog_clk);
        pReset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_load($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].g0, vecs[i].g1,
                     vecs[i].inj, vecs[i].sic, vecs[i].exp_done, vecs[i].exp_err, vecs[i].chk_chain);
        end

        // Restart from DONE: done must drop right after the start edge.
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        check_eq("done_restart", {busy, done}, 2'b10);

        // Reset mid-load after 20 shifted bits.
        word_valid = 1'b1; word_data = 32'hA5A5A5A5;
        sh = 0;
        for (int k = 0; k < 100 && sh < 20; k++) begin
            @(negedge prog_clk);
            if (ccff_shift_en) sh++;
            if (sh < 20) begin
                @(posedge prog_clk);
                #1;
            end
        end
        check_eq("shifted_before_reset", sh, 20);
        #2;
        pReset = 1'b1;
        #1;
        check_eq("reset_midload", {word_ready, ccff_shift_en, ccff_head, busy, done, error}, 0);
        word_valid = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b0;
        @(negedge prog_clk);
        check_eq("idle_after_reset", {busy, done}, 2'b00);
        run_load("reload", 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0, 1'b0, 1'b0, 122, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            rw0 = $urandom; rw1 = $urandom;
            rg0 = $urandom_range(0, 4); rg1 = $urandom_range(0, 6);
            run_load($sformatf("rnd%0d", r), rw0, rw1, rg0, rg1, 1'b0, 1'b0,
                     122 + rg0 + rg1, 1'b0, 1'b1);
        end

        // Small instance: one 8-bit word feeds a 6-bit chain, top two bits dropped.
        sw = 8'hC6;
        @(negedge prog_clk);
        s_start = 1'b1;
        @(posedge prog_clk);
        #1;
        s_start = 1'b0; s_valid = 1'b1; s_data = sw;
        sh = 0; xfers = 0; done_cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge prog_clk);
            if (s_done) begin
                done_cyc = k;
                break;
            end
            if (s_sen) sh++;
            if (s_valid && s_ready) xfers++;
            @(posedge prog_clk);
            #1;
        end
        s_valid = 1'b0;
        for (int j = 0; j < 6; j++) e6[5-j] = sw[j];
        check_eq("small_done_cycle", done_cyc, 14);
        check_eq("small_transfers", xfers, 1);
        check_eq("small_shift_cycles", sh, 12);
        check_eq("small_chain", chain6, e6);
        check_eq("small_error", s_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
